// File: rtl/leddc_frame_sched.sv
// Frame/scan scheduler for the ping-pong pixel SRAM. It sequences the SRAM reads that fill the PWM
// buffer for each scan line, and at each Vsync rising edge it either swaps the banks or repeats the frame.
module leddc_frame_sched #(
    parameter int SCANS      = 32,
    parameter int WPS        = 8,
    parameter int PWM_CYCLES = 256,
    parameter int AW         = 8
) (
    input  logic          GCK,
    input  logic          rst_n,
    input  logic          Vsync,
    input  logic          mode,
    input  logic          wr_done,
    output logic          wr_bank,
    output logic          rd_en,
    output logic [AW:0]   rd_addr,
    output logic          ld_valid,
    output logic [2:0]    ld_idx,
    output logic          pwm_en,
    output logic [4:0]    scan,
    output logic          round,
    output logic          frame_drop,
    output logic          overrun
);

    localparam int KW = $clog2(WPS + 1);
    localparam int CW = $clog2(PWM_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, PWM} state_t;

    state_t          state, state_nx;
    logic [KW-1:0]   k, k_nx;
    logic [CW-1:0]   pwm_cnt, cnt_nx;
    logic [4:0]      scan_nx;
    logic            rd_bank;
    logic            pending;
    logic            vs_d;
    logic            vs_rise;
    logic [AW-1:0]   word_addr;

    assign vs_rise   = Vsync & ~vs_d;
    assign wr_bank   = ~rd_bank;
    assign rd_en     = (state == LOAD) && (k < KW'(WPS));
    assign pwm_en    = (state == PWM);
    assign word_addr = AW'(scan) * AW'(WPS) + AW'(k);
    assign rd_addr   = rd_en ? {rd_bank, word_addr} : '0;

    always_ff @(posedge GCK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            pwm_cnt <= '0;
            scan    <= '0;
        end else begin
            state   <= state_nx;
            k       <= k_nx;
            pwm_cnt <= cnt_nx;
            scan    <= scan_nx;
        end
    end

    // LOAD spends one extra cycle (k == WPS) so the last read's data lands before PWM starts.
    always_comb begin
        state_nx = state;
        k_nx     = k;
        cnt_nx   = pwm_cnt;
        scan_nx  = scan;
        case (state)
            IDLE: ;
            LOAD: begin
                if (k == KW'(WPS)) begin
                    state_nx = PWM;
                    cnt_nx   = '0;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            PWM: begin
                if (pwm_cnt == CW'(PWM_CYCLES - 1)) begin
                    if (scan == 5'(SCANS - 1)) begin
                        state_nx = IDLE;
                    end else begin
                        scan_nx  = scan + 1'b1;
                        state_nx = LOAD;
                        k_nx     = '0;
                    end
                end else begin
                    cnt_nx = pwm_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (vs_rise) begin
            state_nx = LOAD;
            scan_nx  = '0;
            k_nx     = '0;
            cnt_nx   = '0;
        end
    end

    // A read in flight when Vsync rises belongs to the abandoned frame, so its data is never flagged.
    always_ff @(posedge GCK or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b1;
            rd_bank    <= 1'b0;
            pending    <= 1'b0;
            round      <= 1'b0;
            ld_valid   <= 1'b0;
            ld_idx     <= '0;
            frame_drop <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vs_d       <= Vsync;
            ld_valid   <= rd_en & ~vs_rise;
            ld_idx     <= (rd_en && !vs_rise) ? 3'(k) : 3'd0;
            frame_drop <= wr_done & pending & ~vs_rise;
            overrun    <= vs_rise & (state != IDLE);
            if (vs_rise) begin
                if (pending || wr_done) begin
                    rd_bank <= ~rd_bank;
                    pending <= 1'b0;
                    round   <= 1'b0;
                end else begin
                    round <= mode & ~round;
                end
            end else if (wr_done) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_leddc_frame_sched.sv
// Bench for leddc_frame_sched: a hand-derived vector table, directed corner sequences and a
// randomized run, all checked against a frame-position model built from plain arithmetic.
module tb_leddc_frame_sched;

    localparam int SCAN_LEN  = 265;
    localparam int FRAME_LEN = 32 * SCAN_LEN;

    logic       GCK = 1'b0;
    logic       rst_n = 1'b0;
    logic       Vsync = 1'b1;
    logic       mode = 1'b0;
    logic       wr_done = 1'b0;
    logic       wr_bank, rd_en, ld_valid, pwm_en, round, frame_drop, overrun;
    logic [8:0] rd_addr;
    logic [2:0] ld_idx;
    logic [4:0] scan;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    leddc_frame_sched dut (
        .GCK(GCK), .rst_n(rst_n), .Vsync(Vsync), .mode(mode), .wr_done(wr_done),
        .wr_bank(wr_bank), .rd_en(rd_en), .rd_addr(rd_addr), .ld_valid(ld_valid),
        .ld_idx(ld_idx), .pwm_en(pwm_en), .scan(scan), .round(round),
        .frame_drop(frame_drop), .overrun(overrun)
    );

    always #5 GCK = ~GCK;

    // Reference model: where we are in the frame, counted in cycles since the last Vsync rise.
    bit m_active, m_vs_d, m_bank, m_pending, m_round, m_drop, m_over;
    int m_t, m_idle_scan;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_vs_d = 1; m_bank = 0; m_pending = 0; m_round = 0;
        m_drop = 0; m_over = 0; m_t = 0; m_idle_scan = 0;
    endtask

    task automatic model_update(input bit vs, input bit md, input bit wd);
        bit rise;
        rise   = vs && !m_vs_d;
        m_vs_d = vs;
        m_drop = wd && m_pending && !rise;
        m_over = rise && m_active;
        if (rise) begin
            if (m_pending || wd) begin
                m_bank = !m_bank; m_pending = 0; m_round = 0;
            end else begin
                m_round = md ? !m_round : 1'b0;
            end
            m_active = 1; m_t = 0;
        end else begin
            if (wd) m_pending = 1;
            if (m_active) begin
                m_t++;
                if (m_t == FRAME_LEN) begin
                    m_active = 0; m_idle_scan = 31;
                end
            end
        end
    endtask

    task automatic compare_model();
        int off, sc;
        bit e_rd, e_ld, e_pwm;
        logic [8:0] e_addr;
        logic [2:0] e_idx;
        off = m_t % SCAN_LEN;
        sc  = m_active ? m_t / SCAN_LEN : m_idle_scan;
        e_rd   = m_active && off < 8;
        e_ld   = m_active && off >= 1 && off <= 8;
        e_pwm  = m_active && off >= 9;
        e_addr = e_rd ? {m_bank, 8'(sc * 8 + off)} : 9'd0;
        e_idx  = e_ld ? 3'(off - 1) : 3'd0;
        check("m_wr_bank", wr_bank, !m_bank);
        check("m_rd_en", rd_en, e_rd);
        check("m_rd_addr", rd_addr, e_addr);
        check("m_ld_valid", ld_valid, e_ld);
        check("m_ld_idx", ld_idx, e_idx);
        check("m_pwm_en", pwm_en, e_pwm);
        check("m_scan", scan, sc);
        check("m_round", round, m_round);
        check("m_frame_drop", frame_drop, m_drop);
        check("m_overrun", overrun, m_over);
    endtask

    task automatic step(input bit vs, input bit md, input bit wd);
        Vsync = vs; mode = md; wr_done = wd;
        @(posedge GCK);
        cyc++;
        model_update(vs, md, wd);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_bank"}, wr_bank, 1'b1);
        check({tag, "_outs"}, {rd_en, rd_addr, ld_valid, ld_idx, pwm_en, scan, round, frame_drop, overrun}, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; Vsync = 1'b1; mode = 1'b0; wr_done = 1'b0;
        repeat (3) @(posedge GCK);
        #1;
        check_all_zero("reset");
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic       vs, md, wd;
        logic       e_wr, e_round, e_drop, e_over, e_rd_en;
        logic [8:0] e_addr;
    } vec_t;

    vec_t tbl[32];

    task automatic set_row(input int i, input logic [2:0] in, input logic [4:0] ex, input logic [8:0] a);
        tbl[i] = {in, ex, a};
    endtask

    int n_rd, n_ld, n_pwm, first_ld, first_pwm;
    logic [8:0] first_addr;

    initial begin
        // {vs,md,wd}, {wr_bank,round,frame_drop,overrun,rd_en}, rd_addr
        set_row( 0, 3'b100, 5'b10000, 9'h000); set_row( 1, 3'b000, 5'b10000, 9'h000);
        set_row( 2, 3'b001, 5'b10000, 9'h000); set_row( 3, 3'b100, 5'b00001, 9'h100);
        set_row( 4, 3'b100, 5'b00001, 9'h101); set_row( 5, 3'b000, 5'b00001, 9'h102);
        set_row( 6, 3'b100, 5'b00011, 9'h100); set_row( 7, 3'b010, 5'b00001, 9'h101);
        set_row( 8, 3'b110, 5'b01011, 9'h100); set_row( 9, 3'b010, 5'b01001, 9'h101);
        set_row(10, 3'b110, 5'b00011, 9'h100); set_row(11, 3'b010, 5'b00001, 9'h101);
        set_row(12, 3'b110, 5'b01011, 9'h100); set_row(13, 3'b010, 5'b01001, 9'h101);
        set_row(14, 3'b110, 5'b00011, 9'h100); set_row(15, 3'b010, 5'b00001, 9'h101);
        set_row(16, 3'b110, 5'b01011, 9'h100); set_row(17, 3'b000, 5'b01001, 9'h101);
        set_row(18, 3'b100, 5'b00011, 9'h100); set_row(19, 3'b001, 5'b00001, 9'h101);
        set_row(20, 3'b000, 5'b00001, 9'h102); set_row(21, 3'b001, 5'b00101, 9'h103);
        set_row(22, 3'b000, 5'b00001, 9'h104); set_row(23, 3'b100, 5'b10011, 9'h000);
        set_row(24, 3'b000, 5'b10001, 9'h001); set_row(25, 3'b101, 5'b00011, 9'h100);
        set_row(26, 3'b000, 5'b00001, 9'h101); set_row(27, 3'b100, 5'b00011, 9'h100);
        set_row(28, 3'b010, 5'b00001, 9'h101); set_row(29, 3'b110, 5'b01011, 9'h100);
        set_row(30, 3'b011, 5'b01001, 9'h101); set_row(31, 3'b110, 5'b10011, 9'h000);

        // Full frame after reset released with Vsync held high.
        do_reset();
        repeat (3) step(1, 0, 0);
        check("pre_rise_idle", {rd_en, pwm_en, ld_valid}, 3'b000);
        repeat (2) step(0, 0, 0);
        n_rd = 0; n_ld = 0; n_pwm = 0; first_ld = -1; first_pwm = -1; first_addr = 9'h1ff;
        for (int c = 0; c < FRAME_LEN; c++) begin
            step(c == 0, 0, 0);
            if (c == 0) first_addr = rd_addr;
            if (rd_en) n_rd++;
            if (ld_valid) begin
                n_ld++;
                if (first_ld < 0) first_ld = c;
            end
            if (pwm_en) begin
                n_pwm++;
                if (first_pwm < 0) first_pwm = c;
            end
        end
        check("first_addr", first_addr, 9'h000);
        check("first_ld_cycle", first_ld, 1);
        check("first_pwm_cycle", first_pwm, 9);
        check("rd_en_count", n_rd, 32 * 8);
        check("ld_valid_count", n_ld, 32 * 8);
        check("pwm_en_count", n_pwm, 32 * 256);
        step(0, 0, 0);
        check("frame_end_idle", {rd_en, pwm_en, scan}, {2'b00, 5'd31});

        // Bank swap, repeat, 60fps rounding, frame drop and coincident wr_done.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(tbl[i].vs, tbl[i].md, tbl[i].wd);
            check($sformatf("tbl%0d_wr_bank", i), wr_bank, tbl[i].e_wr);
            check($sformatf("tbl%0d_round", i), round, tbl[i].e_round);
            check($sformatf("tbl%0d_frame_drop", i), frame_drop, tbl[i].e_drop);
            check($sformatf("tbl%0d_overrun", i), overrun, tbl[i].e_over);
            check($sformatf("tbl%0d_rd_en", i), rd_en, tbl[i].e_rd_en);
            check($sformatf("tbl%0d_rd_addr", i), rd_addr, tbl[i].e_addr);
        end

        // Vsync rising during PWM of scan 5.
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (1384) step(0, 0, 0);
        check("pre_ovr_pwm", {scan, pwm_en}, {5'd5, 1'b1});
        step(1, 0, 0);
        check("ovr_pwm_pulse", overrun, 1'b1);
        check("ovr_pwm_restart", {scan, rd_en, rd_addr[7:0], ld_valid}, {5'd0, 1'b1, 8'd0, 1'b0});

        // Vsync rising during LOAD at k=3: the in-flight read is discarded.
        repeat (3) step(0, 0, 0);
        check("pre_ovr_load", {rd_en, rd_addr[7:0]}, {1'b1, 8'd3});
        step(1, 0, 0);
        check("ovr_load_pulse", overrun, 1'b1);
        check("ovr_load_restart", {rd_en, rd_addr[7:0], ld_valid}, {1'b1, 8'd0, 1'b0});
        step(0, 0, 0);
        check("ovr_load_first_ld", {ld_valid, ld_idx}, {1'b1, 3'd0});

        // Asynchronous reset in the middle of LOAD.
        repeat (2) step(0, 0, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        do_reset();

        // Randomized Vsync/wr_done/mode traffic.
        for (int seg = 0; seg < 40; seg++) begin
            bit md;
            int hold;
            md = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3)) step(0, md, $urandom_range(0, 39) == 0);
            hold = ($urandom_range(0, 11) == 0) ? 8600 : $urandom_range(1, 700);
            repeat (hold) step(1, md, $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 20; j++) step(j[0], md, 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
